// File: rtl/fix2float_pkg.sv
// rtl/fix2float_pkg.sv - shared types and width helpers for the fixed-to-float pipeline
package fix2float_pkg;

  // Stage registers are sized for the widest supported operand; narrower inputs are zero-extended.
  localparam int MAX_FIX_W = 64;
  localparam int SE_W      = 16;
  localparam int FLT_W     = 1 + 8 + 23;
  localparam int E_BIAS    = 127;

  typedef logic signed [SE_W-1:0] sexp_t;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic nx;
  } flags_t;

  typedef struct packed {
    logic                 sign;
    logic [MAX_FIX_W-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic [MAX_FIX_W-1:0] frac;
    sexp_t                bexp;
  } s2_t;

  function automatic int flt_w(input int ew, input int mw);
    return 1 + ew + mw;
  endfunction

  function automatic int e_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

endpackage

// File: rtl/fix2float_if.sv
// rtl/fix2float_if.sv - operand/result handshake bundle for fix2float_pipe
interface fix2float_if #(
  parameter int FIX_W = 64,
  parameter int FLT_W = 32
);
  import fix2float_pkg::*;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [FIX_W-1:0] fix_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [FLT_W-1:0] float_o;
  flags_t           flags_o;

  modport master (
    output in_valid_i, fix_i, out_ready_i,
    input  in_ready_o, out_valid_o, float_o, flags_o
  );

  modport slave (
    input  in_valid_i, fix_i, out_ready_i,
    output in_ready_o, out_valid_o, float_o, flags_o
  );

endinterface

// File: rtl/fix2float_lzc.sv
// rtl/fix2float_lzc.sv - leading-one locator by successive halving
module fix2float_lzc #(
  parameter int W = 64
) (
  input  logic [W-1:0]         x,
  output logic                 zero,
  output logic [$clog2(W)-1:0] p
);

  localparam int LW = $clog2(W);

  logic [W-1:0] v;

  // Each step asks whether the leading one lies in the upper half of the remaining window.
  always_comb begin
    v = x;
    p = '0;
    for (int k = LW - 1; k >= 0; k--) begin
      if ((v >> (1 << k)) != '0) begin
        p[k] = 1'b1;
        v    = v >> (1 << k);
      end
    end
  end

  assign zero = (x == '0);

endmodule

// File: rtl/fix2float_pipe.sv
// rtl/fix2float_pipe.sv - 3-stage fixed-point to float converter; FIX2FLOAT_RNE_EN selects round-to-nearest-even
module fix2float_pipe
  import fix2float_pkg::*;
#(
  parameter int FIX_W     = 64,
  parameter int FRAC_W    = 32,
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter bit SIGNED_IN = 1'b1
) (
  input logic         clk_i,
  input logic         rst_ni,
  fix2float_if.slave  bus
);

  localparam int OUT_W    = flt_w(EXP_W, MAN_W);
  localparam int BIAS     = e_bias(EXP_W);
  localparam int MAX_E    = (1 << EXP_W) - 1;
  localparam int LZ_W     = $clog2(MAX_FIX_W);
  localparam bit NO_ROUND = (FIX_W <= MAN_W + 1);

  logic en;
  logic v1, v2, v3;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [OUT_W-1:0] float_d, float_q;
  flags_t           flags_d, flags_q;

  assign en             = !v3 || bus.out_ready_i;
  assign bus.in_ready_o = en;
  assign bus.out_valid_o = v3;
  assign bus.float_o    = float_q;
  assign bus.flags_o    = flags_q;

  logic [FIX_W-1:0] mag_f;

  always_comb begin
    s1_d.sign = SIGNED_IN && bus.fix_i[FIX_W-1];
    mag_f     = s1_d.sign ? -bus.fix_i : bus.fix_i;
    s1_d.mag  = MAX_FIX_W'(mag_f);
  end

  logic            lz_zero;
  logic [LZ_W-1:0] lz_p;

  fix2float_lzc #(.W(MAX_FIX_W)) u_lzc (
    .x    (s1_q.mag),
    .zero (lz_zero),
    .p    (lz_p)
  );

  // The leading one is shifted out entirely; frac holds only the bits below it.
  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.zero = lz_zero;
    s2_d.frac = (s1_q.mag << (LZ_W'(MAX_FIX_W - 1) - lz_p)) << 1;
    s2_d.bexp = sexp_t'(lz_p) - sexp_t'(FRAC_W) + sexp_t'(BIAS);
  end

  logic [MAN_W-1:0] man_t;
  logic [MAN_W:0]   man_r;
  logic             guard, sticky, round_up, nx_raw;
  sexp_t            bexp_r;

  always_comb begin
    man_t  = s2_q.frac[MAX_FIX_W-1 -: MAN_W];
    guard  = s2_q.frac[MAX_FIX_W-1-MAN_W];
    sticky = |s2_q.frac[MAX_FIX_W-2-MAN_W:0];
    nx_raw = NO_ROUND ? 1'b0 : (guard | sticky);
`ifdef FIX2FLOAT_RNE_EN
    round_up = guard & (sticky | man_t[0]);
`else
    round_up = 1'b0;
`endif
    man_r  = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
    bexp_r = s2_q.bexp + sexp_t'(man_r[MAN_W]);

    float_d = '0;
    flags_d = '0;
    if (s2_q.zero) begin
      float_d = '0;
    end else if (bexp_r >= sexp_t'(MAX_E)) begin
      float_d     = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d.ovf = 1'b1;
      flags_d.nx  = 1'b1;
    end else if (bexp_r <= sexp_t'(0)) begin
      float_d     = {s2_q.sign, {(OUT_W-1){1'b0}}};
      flags_d.unf = 1'b1;
      flags_d.nx  = 1'b1;
    end else begin
      float_d    = {s2_q.sign, bexp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
      flags_d.nx = nx_raw;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      float_q <= '0;
      flags_q <= '0;
    end else if (en) begin
      v1      <= bus.in_valid_i;
      s1_q    <= s1_d;
      v2      <= v1;
      s2_q    <= s2_d;
      v3      <= v2;
      float_q <= float_d;
      flags_q <= flags_d;
    end
  end

endmodule
